// File: rtl/led_flow_ctrl.sv
// led_flow_ctrl: one-hot "flowing light" driver for an LED bank.
// The divider's slow output arrives on tick_in as an asynchronous level. It is
// synchronised into the clk domain, and each rising edge becomes a one-cycle step.
// Each step that is accepted advances the pattern according to mode.
// Optional feature macro: LED_FLOW_PINGPONG_EN. When it is defined, mode 11 is a
// ping-pong sweep. When it is not defined, mode 11 holds the pattern.
module led_flow_ctrl #(
    parameter int N_LED = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_in,
    input  logic             en,
    input  logic [1:0]       mode,
    output logic [N_LED-1:0] led,
    output logic [CNT_W-1:0] step_cnt,
    output logic             wrap
);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_LEFT  = 2'b01;
    localparam logic [1:0] MODE_RIGHT = 2'b10;
    localparam logic [1:0] MODE_PING  = 2'b11;

    localparam logic [N_LED-1:0] LED_INIT = N_LED'(1);

    // The two-flop synchroniser is s1/s2. s3 holds the previous synced level, used for edge detection.
    logic s1, s2, s3;
    logic step;
    logic mode_active;
    logic accept;

    logic [N_LED-1:0] led_nxt;
    logic             wrap_nxt;

`ifdef LED_FLOW_PINGPONG_EN
    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    dir_t dir;
    dir_t dir_eff;
    dir_t dir_nxt;
`endif

    // Synchronise tick_in into clk. The chain keeps running while en=0, so a level that is already high never produces a step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= tick_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign step = s2 & ~s3;

    // Decide which modes move the pattern. Without ping-pong, mode 11 is a second hold.
    always_comb begin
`ifdef LED_FLOW_PINGPONG_EN
        mode_active = (mode != MODE_HOLD);
`else
        mode_active = (mode == MODE_LEFT) || (mode == MODE_RIGHT);
`endif
    end

    assign accept = step & en & mode_active;

    // Compute the next pattern position and the wrap flag for an accepted step.
    always_comb begin
        led_nxt  = led;
        wrap_nxt = 1'b0;
`ifdef LED_FLOW_PINGPONG_EN
        dir_nxt  = dir;
        dir_eff  = dir;
`endif
        if (accept) begin
            case (mode)
                MODE_LEFT: begin
                    led_nxt  = {led[N_LED-2:0], led[N_LED-1]};
                    wrap_nxt = led[N_LED-1];
                end
                MODE_RIGHT: begin
                    led_nxt  = {led[0], led[N_LED-1:1]};
                    wrap_nxt = led[0];
                end
`ifdef LED_FLOW_PINGPONG_EN
                MODE_PING: begin
                    // At an end, the sweep must turn inward whatever dir says.
                    if (led[0]) begin
                        dir_eff = DIR_LEFT;
                    end else if (led[N_LED-1]) begin
                        dir_eff = DIR_RIGHT;
                    end
                    if (dir_eff == DIR_LEFT) begin
                        led_nxt = {led[N_LED-2:0], 1'b0};
                        dir_nxt = led_nxt[N_LED-1] ? DIR_RIGHT : DIR_LEFT;
                    end else begin
                        led_nxt = {1'b0, led[N_LED-1:1]};
                        if (led_nxt[0]) begin
                            dir_nxt  = DIR_LEFT;
                            wrap_nxt = 1'b1;
                        end else begin
                            dir_nxt  = DIR_RIGHT;
                        end
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

    // Register the pattern, the step count and the wrap pulse. An empty (illegal) pattern is reloaded before any step is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led      <= LED_INIT;
            step_cnt <= '0;
            wrap     <= 1'b0;
        end else if (led == '0) begin
            led      <= LED_INIT;
            wrap     <= 1'b0;
        end else begin
            led      <= led_nxt;
            wrap     <= wrap_nxt;
            if (accept) begin
                step_cnt <= step_cnt + CNT_W'(1);
            end
        end
    end

`ifdef LED_FLOW_PINGPONG_EN
    // Sweep direction. It keeps its value outside mode 11 and while the pattern is being reloaded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir <= DIR_LEFT;
        end else if (led != '0) begin
            dir <= dir_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_led_flow_ctrl.sv
// Bench for led_flow_ctrl (N_LED=16, CNT_W=8).
// A position-based reference model checks every cycle. A table of scenarios
// starts from reset, and hand sequences cover latency, en, and mid-cycle reset.
module tb_led_flow_ctrl;

    localparam int N = 16;

    logic        clk;
    logic        rst;
    logic        tick_in;
    logic        en;
    logic [1:0]  mode;
    logic [15:0] led;
    logic [7:0]  step_cnt;
    logic        wrap;

    int checks   = 0;
    int failures = 0;
    int wrap_seen = 0;

    led_flow_ctrl #(.N_LED(16), .CNT_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .tick_in  (tick_in),
        .en       (en),
        .mode     (mode),
        .led      (led),
        .step_cnt (step_cnt),
        .wrap     (wrap)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef LED_FLOW_PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: LED position as an integer, direction as a flag.
    // A step lands at edge E when tick_in was sampled 0 at E-3 and 1 at E-2.
    int m_pos;
    bit m_left;
    int m_cnt;
    bit m_wrap;
    bit h1, h2, h3;

    always @(posedge clk or posedge rst) begin : model
        int p;
        bit l;
        int c;
        bit w;
        if (rst) begin
            m_pos  <= 0;
            m_left <= 1'b1;
            m_cnt  <= 0;
            m_wrap <= 1'b0;
            h1 <= 1'b0; h2 <= 1'b0; h3 <= 1'b0;
        end else begin
            p = m_pos; l = m_left; c = m_cnt; w = 1'b0;
            if (h2 && !h3 && en && (mode == 2'd1 || mode == 2'd2 || (mode == 2'd3 && PP))) begin
                c = (c + 1) % 256;
                if (mode == 2'd1) begin
                    if (p == N - 1) w = 1'b1;
                    p = (p + 1) % N;
                end else if (mode == 2'd2) begin
                    if (p == 0) w = 1'b1;
                    p = (p + N - 1) % N;
                end else begin
                    if (p == 0) l = 1'b1;
                    if (p == N - 1) l = 1'b0;
                    if (l) begin
                        p = p + 1;
                        if (p == N - 1) l = 1'b0;
                    end else begin
                        p = p - 1;
                        if (p == 0) begin
                            l = 1'b1;
                            w = 1'b1;
                        end
                    end
                end
            end
            m_pos  <= p;
            m_left <= l;
            m_cnt  <= c;
            m_wrap <= w;
            h3 <= h2; h2 <= h1; h1 <= tick_in;
        end
    end

    // Scoreboard: compare the DUT with the model every cycle, on the falling edge.
    always @(negedge clk) begin
        chk("model_led", {16'h0, led}, 32'(16'(1) << m_pos));
        chk("model_cnt", {24'h0, step_cnt}, 32'(m_cnt));
        chk("model_wrap", {31'h0, wrap}, {31'h0, m_wrap});
        if (wrap === 1'b1) wrap_seen++;
    end

    // Watchdog
    initial begin
        repeat (100000) @(posedge clk);
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Driver tasks. All driving happens 1 time unit after a rising clk edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        tick_in = 1'b0;
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(2);
    endtask

    task automatic tick_pulse(input int hi, input int lo);
        tick_in = 1'b1;
        cyc(hi);
        tick_in = 1'b0;
        cyc(lo);
    endtask

    typedef struct {
        logic [1:0]  mode;
        logic        en;
        int          ticks;
        logic [15:0] exp_led;
        int          exp_cnt;
        int          exp_wraps;
    } vec_t;

    vec_t vecs[11];

    initial begin
        rst = 1'b1;
        tick_in = 1'b0;
        en = 1'b0;
        mode = 2'd0;

        vecs[0]  = '{2'd1, 1'b1, 1,  16'h0002, 1,  0};
        vecs[1]  = '{2'd1, 1'b1, 16, 16'h0001, 16, 1};
        vecs[2]  = '{2'd2, 1'b1, 1,  16'h8000, 1,  1};
        vecs[3]  = '{2'd2, 1'b1, 2,  16'h4000, 2,  1};
        vecs[4]  = '{2'd0, 1'b1, 5,  16'h0001, 0,  0};
        vecs[5]  = '{2'd1, 1'b0, 5,  16'h0001, 0,  0};
        vecs[6]  = '{2'd1, 1'b1, 5,  16'h0020, 5,  0};
        vecs[7]  = '{2'd2, 1'b1, 17, 16'h8000, 17, 2};
        if (PP) begin
            vecs[8]  = '{2'd3, 1'b1, 15, 16'h8000, 15, 0};
            vecs[9]  = '{2'd3, 1'b1, 16, 16'h4000, 16, 0};
            vecs[10] = '{2'd3, 1'b1, 30, 16'h0001, 30, 1};
        end else begin
            vecs[8]  = '{2'd3, 1'b1, 15, 16'h0001, 0, 0};
            vecs[9]  = '{2'd3, 1'b1, 16, 16'h0001, 0, 0};
            vecs[10] = '{2'd3, 1'b1, 30, 16'h0001, 0, 0};
        end

        // Check the reset state while reset is still asserted.
        cyc(2);
        chk("reset_led", {16'h0, led}, 32'h0001);
        chk("reset_cnt", {24'h0, step_cnt}, 32'h0);
        chk("reset_wrap", {31'h0, wrap}, 32'h0);
        rst = 1'b0;
        cyc(2);

        // Latency: the step lands on the 3rd edge after the rise. A long high level gives only one step.
        mode = 2'd1; en = 1'b1;
        tick_in = 1'b1;
        cyc(1);
        chk("lat_e1", {16'h0, led}, 32'h0001);
        cyc(1);
        chk("lat_e2", {16'h0, led}, 32'h0001);
        cyc(1);
        chk("lat_e3", {16'h0, led}, 32'h0002);
        cyc(47);
        chk("long_high_led", {16'h0, led}, 32'h0002);
        chk("long_high_cnt", {24'h0, step_cnt}, 32'h1);
        tick_in = 1'b0;
        cyc(4);

        // Table of scenarios. Each one starts from reset.
        for (int i = 0; i < 11; i++) begin
            apply_reset();
            mode = vecs[i].mode;
            en = vecs[i].en;
            wrap_seen = 0;
            for (int t = 0; t < vecs[i].ticks; t++) tick_pulse(3, 3);
            cyc(3);
            chk($sformatf("vec%0d_led", i), {16'h0, led}, {16'h0, vecs[i].exp_led});
            chk($sformatf("vec%0d_cnt", i), {24'h0, step_cnt}, 32'(vecs[i].exp_cnt));
            chk($sformatf("vec%0d_wraps", i), 32'(wrap_seen), 32'(vecs[i].exp_wraps));
        end

        // Raise en while tick_in is high. No step may occur until the next rise.
        apply_reset();
        mode = 2'd1; en = 1'b0;
        tick_in = 1'b1;
        cyc(5);
        en = 1'b1;
        cyc(10);
        chk("en_rise_led", {16'h0, led}, 32'h0001);
        chk("en_rise_cnt", {24'h0, step_cnt}, 32'h0);
        tick_in = 1'b0;
        cyc(3);
        tick_pulse(3, 3);
        chk("en_next_rise_led", {16'h0, led}, 32'h0002);

        // Assert reset between clk edges in the middle of a sweep.
        apply_reset();
        mode = 2'd1; en = 1'b1;
        for (int t = 0; t < 8; t++) tick_pulse(3, 3);
        chk("pre_rst_led", {16'h0, led}, 32'h0100);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_led", {16'h0, led}, 32'h0001);
        chk("async_rst_cnt", {24'h0, step_cnt}, 32'h0);
        #1;
        rst = 1'b0;
        cyc(2);
        tick_pulse(3, 3);
        chk("post_rst_led", {16'h0, led}, 32'h0002);

        // 256 steps wrap step_cnt back to 0.
        apply_reset();
        mode = 2'd1; en = 1'b1;
        for (int t = 0; t < 256; t++) tick_pulse(3, 3);
        chk("cnt_wrap_cnt", {24'h0, step_cnt}, 32'h0);
        chk("cnt_wrap_led", {16'h0, led}, 32'h0001);

        // Random traffic: varied tick lengths, and mode/en changes at random cycles.
        apply_reset();
        mode = 2'd1; en = 1'b1;
        begin
            int left;
            left = $urandom_range(1, 6);
            for (int c = 0; c < 4000; c++) begin
                if (left == 0) begin
                    tick_in = ~tick_in;
                    left = $urandom_range(1, 6);
                end
                left--;
                if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 29) == 0) en = ($urandom_range(0, 3) != 0);
                cyc(1);
            end
        end
        tick_in = 1'b0;
        cyc(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
